// File: rtl/regbus_pkg.sv
// rtl/regbus_pkg.sv - shared widths, command record and FSM state encoding for the register-bus initiator
package regbus_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 16;

    // One queued register-bus operation; wdata is don't-care for reads.
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/regbus_if.sv
// rtl/regbus_if.sv - command, register-bus and read-response signal bundle
interface regbus_if;
    import regbus_pkg::*;

    // command intake
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    // register bus
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;

    // read response
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ADDR_W-1:0] rsp_addr;
    logic [DATA_W-1:0] rsp_rdata;

    logic              busy;

    // The initiator drives the bus and the response; it consumes commands.
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, read_data, rsp_ready,
        output cmd_ready, wr_en, rd_en, addr, write_data,
               rsp_valid, rsp_addr, rsp_rdata, busy
    );

    // Command source / register target / response sink side.
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, read_data, rsp_ready,
        input  cmd_ready, wr_en, rd_en, addr, write_data,
               rsp_valid, rsp_addr, rsp_rdata, busy
    );

endinterface

// File: rtl/regbus_cmd_fifo.sv
// rtl/regbus_cmd_fifo.sv - synchronous command FIFO with registered occupancy count
module regbus_cmd_fifo
    import regbus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output cmd_t pop_data,
    output logic full,
    output logic empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Flags come from the registered count only, so a pop never frees a slot
    // for a push in the same cycle.
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: empty pointers make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/regbus_initiator.sv
// rtl/regbus_initiator.sv - queued command executor driving a strobe-based register bus
module regbus_initiator
    import regbus_pkg::*;
#(
    parameter int CMD_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    regbus_if.master bus
);

    state_t            state_q;
    state_t            state_d;
    cmd_t              cmd_in;
    cmd_t              head;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              load_cmd;
    logic              load_rsp;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] rsp_addr_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    assign cmd_in    = {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
    assign fifo_push = bus.cmd_valid && !fifo_full;

    regbus_cmd_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (cmd_in),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // FSM state register; reset drops any in-flight strobe at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and datapath load decisions: one command at a time, in order.
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        load_cmd = 1'b0;
        load_rsp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    load_cmd = 1'b1;
                    state_d  = head.write ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_READ: begin
                load_rsp = 1'b1;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus address/data hold the last issued command between operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (load_cmd) begin
            addr_q  <= head.addr;
            wdata_q <= head.wdata;
        end
    end

    // Read return is sampled on the edge that closes the read strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_addr_q  <= '0;
            rsp_rdata_q <= '0;
        end else if (load_rsp) begin
            rsp_addr_q  <= addr_q;
            rsp_rdata_q <= bus.read_data;
        end
    end

    // Strobes decode directly from state, so they can never overlap.
    assign bus.wr_en      = (state_q == ST_WRITE);
    assign bus.rd_en      = (state_q == ST_READ);
    assign bus.addr       = addr_q;
    assign bus.write_data = wdata_q;
    assign bus.rsp_valid  = (state_q == ST_RESP);
    assign bus.rsp_addr   = rsp_addr_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.cmd_ready  = !fifo_full;
    assign bus.busy       = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_regbus_initiator.sv
// tb/tb_regbus_initiator.sv - scoreboard bench for regbus_initiator
module tb_regbus_initiator;
    import regbus_pkg::*;

    typedef struct {
        logic [13:0] a;
        logic [15:0] d;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regbus_if bus ();

    regbus_initiator #(
        .CMD_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    cmd_t exp_q[$];
    rsp_t rsp_q[$];

    logic rsp_rand  = 1'b0;
    logic rsp_force = 1'b0;
    logic rsp_bit   = 1'b0;

    function automatic logic [15:0] slave_rdata(logic [13:0] a);
        if (a == 14'h209) return 16'h00AB;
        return {a[7:0], a[13:6]} ^ 16'h3C5A;
    endfunction

    assign bus.read_data = slave_rdata(bus.addr);
    assign bus.rsp_ready = rsp_rand ? rsp_bit : rsp_force;

    always @(posedge clk) begin
        #1 rsp_bit = 1'($urandom_range(0, 1));
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Bus monitor: strobe order/content, response content and stability.
    logic        prev_strobe = 1'b0;
    logic        prev_hold = 1'b0;
    logic [13:0] prev_ra;
    logic [15:0] prev_rd;
    cmd_t        mon_e;
    rsp_t        mon_r;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_strobe = 1'b0;
            prev_hold   = 1'b0;
        end else begin
            check_eq("wr_rd_exclusive", 32'(bus.wr_en && bus.rd_en), 0);
            if (bus.wr_en || bus.rd_en) begin
                check_eq("strobe_one_cycle", 32'(prev_strobe), 0);
                check_eq("strobe_during_resp", 32'(bus.rsp_valid), 0);
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_strobe", {bus.wr_en, bus.rd_en}, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("strobe_kind", 32'(bus.wr_en), 32'(mon_e.write));
                    check_eq("strobe_addr", 32'(bus.addr), 32'(mon_e.addr));
                    if (mon_e.write)
                        check_eq("strobe_wdata", 32'(bus.write_data), 32'(mon_e.wdata));
                end
            end
            if (prev_hold) begin
                check_eq("rsp_hold_valid", 32'(bus.rsp_valid), 1);
                check_eq("rsp_hold_addr", 32'(bus.rsp_addr), 32'(prev_ra));
                check_eq("rsp_hold_rdata", 32'(bus.rsp_rdata), 32'(prev_rd));
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    check_eq("unexpected_rsp", 32'(bus.rsp_valid), 0);
                end else begin
                    mon_r = rsp_q.pop_front();
                    check_eq("rsp_addr", 32'(bus.rsp_addr), 32'(mon_r.a));
                    check_eq("rsp_rdata", 32'(bus.rsp_rdata), 32'(mon_r.d));
                end
            end
            prev_strobe = bus.wr_en || bus.rd_en;
            prev_hold   = bus.rsp_valid && !bus.rsp_ready;
            prev_ra     = bus.rsp_addr;
            prev_rd     = bus.rsp_rdata;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one command until accepted; returns at accept edge + 1.
    task automatic send(input logic w, input logic [13:0] a, input logic [15:0] d);
        logic acc;
        int   n;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.cmd_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.cmd_valid = 1'b0;
        if (!acc) begin
            check_eq("send_timeout", 32'(acc), 1);
        end else begin
            exp_q.push_back('{write: w, addr: a, wdata: d});
            if (!w) rsp_q.push_back('{a: a, d: slave_rdata(a)});
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((bus.busy || exp_q.size() != 0 || rsp_q.size() != 0) && n < 1000) begin
            step(1);
            n++;
        end
        check_eq({tag, "_strobes_left"}, exp_q.size(), 0);
        check_eq({tag, "_rsps_left"}, rsp_q.size(), 0);
        check_eq({tag, "_busy"}, 32'(bus.busy), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int n;
        int strobes;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        rst_n = 1'b0;
        step(3);
        #2 rst_n = 1'b1;
        step(1);

        // reset state
        check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        check_eq("rst_wr_en", 32'(bus.wr_en), 0);
        check_eq("rst_rd_en", 32'(bus.rd_en), 0);
        check_eq("rst_addr", 32'(bus.addr), 0);
        check_eq("rst_write_data", 32'(bus.write_data), 0);
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check_eq("rst_rsp_addr", 32'(bus.rsp_addr), 0);
        check_eq("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
        check_eq("rst_busy", 32'(bus.busy), 0);

        // single write: strobe E1..E2, then idle with address/data held
        rsp_force = 1'b1;
        send(1'b1, 14'h201, 16'h0010);
        check_eq("wr_e0_wr_en", 32'(bus.wr_en), 0);
        step(1);
        check_eq("wr_e1_wr_en", 32'(bus.wr_en), 1);
        check_eq("wr_e1_rd_en", 32'(bus.rd_en), 0);
        check_eq("wr_e1_addr", 32'(bus.addr), 32'h201);
        check_eq("wr_e1_wdata", 32'(bus.write_data), 32'h0010);
        check_eq("wr_e1_busy", 32'(bus.busy), 1);
        step(1);
        check_eq("wr_e2_wr_en", 32'(bus.wr_en), 0);
        check_eq("wr_e2_addr_hold", 32'(bus.addr), 32'h201);
        check_eq("wr_e2_wdata_hold", 32'(bus.write_data), 32'h0010);

        // single read, response held by rsp_ready=0
        rsp_force = 1'b0;
        send(1'b0, 14'h209, 16'h0000);
        step(1);
        check_eq("rd_e1_rd_en", 32'(bus.rd_en), 1);
        check_eq("rd_e1_addr", 32'(bus.addr), 32'h209);
        check_eq("rd_e1_rsp_valid", 32'(bus.rsp_valid), 0);
        step(1);
        check_eq("rd_e2_rd_en", 32'(bus.rd_en), 0);
        check_eq("rd_e2_rsp_valid", 32'(bus.rsp_valid), 1);
        check_eq("rd_e2_rsp_addr", 32'(bus.rsp_addr), 32'h209);
        check_eq("rd_e2_rsp_rdata", 32'(bus.rsp_rdata), 32'h00AB);

        // fill FIFO while stalled in the response state
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 14'(14'h100 + i), 16'(16'hA000 + i));
        end
        check_eq("full_cmd_ready", 32'(bus.cmd_ready), 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 14'h104;
        bus.cmd_wdata = 16'hA004;
        for (int i = 0; i < 6; i++) begin
            step(1);
            check_eq("stall_cmd_ready", 32'(bus.cmd_ready), 0);
            check_eq("stall_wr_en", 32'(bus.wr_en), 0);
            check_eq("stall_rsp_valid", 32'(bus.rsp_valid), 1);
        end
        rsp_force = 1'b1;
        send(1'b1, 14'h104, 16'hA004);
        drain("fill");

        // reset during a write with three commands still queued
        rsp_force = 1'b0;
        send(1'b0, 14'h300, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 14'(14'h310 + i), 16'(16'hB000 + i));
        end
        rsp_force = 1'b1;
        n = 0;
        while (!bus.wr_en && n < 50) begin
            step(1);
            n++;
        end
        check_eq("midrst_wr_seen", 32'(bus.wr_en), 1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("midrst_wr_en", 32'(bus.wr_en), 0);
        check_eq("midrst_rd_en", 32'(bus.rd_en), 0);
        check_eq("midrst_busy", 32'(bus.busy), 0);
        check_eq("midrst_addr", 32'(bus.addr), 0);
        check_eq("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
        check_eq("midrst_cmd_ready", 32'(bus.cmd_ready), 1);
        exp_q.delete();
        rsp_q.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (bus.wr_en || bus.rd_en) strobes++;
        end
        check_eq("postrst_strobes", strobes, 0);
        check_eq("postrst_busy", 32'(bus.busy), 0);

        // random mix against the scoreboard
        rsp_rand = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) step(1);
            send(1'($urandom_range(0, 1)), 14'($urandom), 16'($urandom));
        end
        drain("rand");
        rsp_rand = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
